// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory port, redirect request and decode handshake
// of the fetch stage so they can be passed around as a single port.
interface fetch_unit_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0] imem_addr_o;
  logic              imem_read_en_o;
  logic [DWIDTH-1:0] imem_data_i;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              insn_valid_o;
  logic              insn_ready_i;
  logic [DWIDTH-1:0] insn_o;
  logic [AWIDTH-1:0] pc_o;
  logic              fault_o;
  logic [31:0]       retire_count_o;

  modport master (
    output imem_addr_o, imem_read_en_o, insn_valid_o, insn_o, pc_o,
           fault_o, retire_count_o,
    input  imem_data_i, redirect_i, redirect_pc_i, insn_ready_i
  );

  modport slave (
    input  imem_addr_o, imem_read_en_o, insn_valid_o, insn_o, pc_o,
           fault_o, retire_count_o,
    output imem_data_i, redirect_i, redirect_pc_i, insn_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, buffers combinationally returned
// words in a small FIFO and hands them to decode over valid/ready.
module fetch_unit #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
  parameter int                DEPTH     = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int              PW   = $clog2(DEPTH);
  localparam logic [PW:0]     FULL = (PW+1)'(DEPTH);

  typedef enum logic {FETCHING, HALTED} state_t;

  state_t            state, state_next;
  logic [AWIDTH-1:0] fetch_pc;
  logic [DWIDTH-1:0] insn_buf [DEPTH];
  logic [AWIDTH-1:0] pc_buf   [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count;
  logic [31:0]       retire_count;
  logic              read_en, push, pop, misaligned, halted;

  assign halted     = (state == HALTED);
  assign misaligned = (bus.redirect_pc_i[1:0] != 2'b00);
  assign read_en    = (count != FULL) && !halted;
  assign push       = read_en && !bus.redirect_i;
  assign pop        = bus.insn_valid_o && bus.insn_ready_i;

  assign bus.imem_addr_o    = fetch_pc;
  assign bus.imem_read_en_o = read_en;
  assign bus.insn_valid_o   = (count != '0) && !bus.redirect_i;
  assign bus.insn_o         = insn_buf[head];
  assign bus.pc_o           = pc_buf[head];
  assign bus.fault_o        = halted;
  assign bus.retire_count_o = retire_count;

  // A misaligned redirect halts fetch permanently; only reset recovers.
  always_comb begin
    state_next = state;
    if (bus.redirect_i && misaligned) begin
      state_next = HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCHING;
    end else begin
      state <= state_next;
    end
  end

  // Redirect flushes the buffer and wins over any push or pop in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= BASE_ADDR;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        insn_buf[i] <= '0;
        pc_buf[i]   <= '0;
      end
    end else if (bus.redirect_i) begin
      fetch_pc <= bus.redirect_pc_i;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        insn_buf[tail] <= bus.imem_data_i;
        pc_buf[tail]   <= fetch_pc;
        tail           <= tail + (PW)'(1);
        fetch_pc       <= fetch_pc + (AWIDTH)'(4);
      end
      if (pop) begin
        head         <= head + (PW)'(1);
        retire_count <= retire_count + 32'd1;
      end
      if (push && !pop) begin
        count <= count + (PW+1)'(1);
      end else if (!push && pop) begin
        count <= count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_fetch_unit;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h01000000;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  entry_t      mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_halt;
  logic [31:0] wlit [4];

  fetch_unit_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  fetch_unit #(
    .AWIDTH(AW), .DWIDTH(DW), .BASE_ADDR(BASE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction

  assign bus.imem_data_i = mem_word(bus.imem_addr_o);

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    mq.delete();
    m_pc   = BASE;
    m_ret  = '0;
    m_halt = 1'b0;
  endtask

  // Advances the model across one rising edge using the inputs held during the cycle.
  task automatic updateModel();
    logic do_pop, do_push;
    if (rst) begin
      resetModel();
    end else if (bus.redirect_i) begin
      mq.delete();
      m_pc = bus.redirect_pc_i;
      if (bus.redirect_pc_i[1:0] != 2'b00) m_halt = 1'b1;
    end else begin
      do_pop  = (mq.size() != 0) && bus.insn_ready_i;
      do_push = (mq.size() != DEPTH) && !m_halt;
      if (do_pop) begin
        void'(mq.pop_front());
        m_ret = m_ret + 32'd1;
      end
      if (do_push) begin
        mq.push_back('{insn: mem_word(m_pc), pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic redir, input logic [31:0] rpc, input logic rdy);
    rst               = r;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.insn_ready_i  = rdy;
    if (r) resetModel();
  endtask

  task automatic checkOutput();
    logic exp_valid;
    exp_valid = (mq.size() != 0) && !bus.redirect_i;
    checkVal("imem_addr", bus.imem_addr_o, m_pc);
    checkVal("imem_read_en", 32'(bus.imem_read_en_o), 32'((mq.size() != DEPTH) && !m_halt));
    checkVal("insn_valid", 32'(bus.insn_valid_o), 32'(exp_valid));
    checkVal("fault", 32'(bus.fault_o), 32'(m_halt));
    checkVal("retire_count", bus.retire_count_o, m_ret);
    if (exp_valid) begin
      checkVal("insn", bus.insn_o, mq[0].insn);
      checkVal("pc", bus.pc_o, mq[0].pc);
    end
    if (rst) begin
      checkVal("insn_rst", bus.insn_o, 32'h0);
      checkVal("pc_rst", bus.pc_o, 32'h0);
    end
  endtask

  // Completes the previous edge in the model, then drives and checks the next cycle.
  task automatic step(input logic r, input logic redir, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    updateModel();
    @(negedge clk);
    applyStimulus(r, redir, rpc, rdy);
    #1;
    checkOutput();
  endtask

  initial begin
    logic        r_rst, r_redir, r_rdy;
    logic [31:0] r_pc;
    wlit[0] = 32'hDFADBEEF;
    wlit[1] = 32'hDFADBEEB;
    wlit[2] = 32'hDFADBEE7;
    wlit[3] = 32'hDFADBEE3;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Reset values and streaming after release.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checkVal("lit_rst_addr", bus.imem_addr_o, 32'h01000000);
    checkVal("lit_rst_valid", 32'(bus.insn_valid_o), 32'h0);
    checkVal("lit_rst_ren", 32'(bus.imem_read_en_o), 32'h1);
    checkVal("lit_rst_fault", 32'(bus.fault_o), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checkVal("lit_release_valid", 32'(bus.insn_valid_o), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checkVal("lit_stream_insn", bus.insn_o, wlit[k]);
      checkVal("lit_stream_pc", bus.pc_o, 32'h01000000 + 32'(4 * k));
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checkVal("lit_retire4", bus.retire_count_o, 32'd4);

    // Backpressure fills the buffer and freezes the fetch PC.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checkVal("lit_stall_addr", bus.imem_addr_o, 32'h01000008);
    checkVal("lit_stall_ren", 32'(bus.imem_read_en_o), 32'h0);
    checkVal("lit_stall_insn", bus.insn_o, wlit[0]);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checkVal("lit_drain_valid", 32'(bus.insn_valid_o), 32'h1);
      checkVal("lit_drain_insn", bus.insn_o, wlit[k]);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect flush with a full buffer.
    step(1'b0, 1'b1, 32'h01000040, 1'b1);
    checkVal("lit_redir_valid0", 32'(bus.insn_valid_o), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checkVal("lit_redir_valid1", 32'(bus.insn_valid_o), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checkVal("lit_redir_pc", bus.pc_o, 32'h01000040);

    // Fetch PC wraps at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFFFFF8, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checkVal("lit_wrap0", bus.imem_addr_o, 32'hFFFFFFF8);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checkVal("lit_wrap1", bus.imem_addr_o, 32'hFFFFFFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checkVal("lit_wrap2", bus.imem_addr_o, 32'h00000000);

    // Misaligned redirect faults, stays sticky, and only reset clears it.
    step(1'b0, 1'b1, 32'h01000042, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checkVal("lit_fault", 32'(bus.fault_o), 32'h1);
    checkVal("lit_fault_ren", 32'(bus.imem_read_en_o), 32'h0);
    checkVal("lit_fault_valid", 32'(bus.insn_valid_o), 32'h0);
    step(1'b0, 1'b1, 32'h01000100, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checkVal("lit_fault_sticky", 32'(bus.fault_o), 32'h1);
    checkVal("lit_fault_addr", bus.imem_addr_o, 32'h01000100);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checkVal("lit_fault_clear", 32'(bus.fault_o), 32'h0);
    checkVal("lit_rst2_addr", bus.imem_addr_o, 32'h01000000);

    // Randomized traffic: backpressure, redirects (some misaligned) and resets.
    for (int n = 0; n < 600; n++) begin
      r_rst   = ($urandom_range(0, 79) == 0);
      r_redir = ($urandom_range(0, 11) == 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_pc    = $urandom();
      if ($urandom_range(0, 5) != 0) r_pc[1:0] = 2'b00;
      step(r_rst, r_redir, r_pc, r_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
